// File: rtl/isa_dma_fifo_target_if.sv
// Chipset-side signal bundle of the I/O-channel DMA FIFO target.
// The master modport is the chipset (CPU/DMA controller); the slave modport is the card.
interface isa_dma_fifo_target_if;
    logic [19:0] address;
    logic        address_enable_n;
    logic        io_read_n;
    logic        io_write_n;
    logic [7:0]  data_bus_in;
    logic [7:0]  data_bus_out;
    logic        data_bus_out_en;
    logic        io_channel_ready;
    logic        dma_request;
    logic        dma_acknowledge_n;
    logic        terminal_count_n;
    logic        interrupt_request;
    logic [1:0]  dma_state_dbg;

    modport master (
        output address, address_enable_n, io_read_n, io_write_n, data_bus_in,
               dma_acknowledge_n, terminal_count_n,
        input  data_bus_out, data_bus_out_en, io_channel_ready, dma_request,
               interrupt_request, dma_state_dbg
    );

    modport slave (
        input  address, address_enable_n, io_read_n, io_write_n, data_bus_in,
               dma_acknowledge_n, terminal_count_n,
        output data_bus_out, data_bus_out_en, io_channel_ready, dma_request,
               interrupt_request, dma_state_dbg
    );
endinterface

// File: rtl/isa_dma_fifo_target.sv
// 8-bit I/O-channel target: buffers producer bytes in a FIFO and drains them through
// CPU port reads or single-mode DREQ/DACK transfers, with wait states and a TC interrupt.
module isa_dma_fifo_target #(
    parameter logic [9:0] BASE_ADDR   = 10'h300,
    parameter int         FIFO_DEPTH  = 16,
    parameter int         WAIT_STATES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    isa_dma_fifo_target_if.slave bus,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2} dma_state_e;

    dma_state_e    state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          dma_en_q, irq_en_q, tc_seen_q, irq_pending_q, tc_latch_q;
    logic [4:0]    thresh_q;
    logic          io_read_n_q, io_write_n_q;
    logic          wr_pend_q;
    logic [1:0]    wr_reg_q;
    logic [7:0]    wr_data_q;
    logic [7:0]    ws_cnt_q;
    logic          dreq_q, irq_q;

    logic       cpu_sel, dma_act, rd_rise, rd_fall, wr_rise, wr_fall;
    logic       empty, full, push, pop, flush, clr, tc_now, thr_met;
    logic [4:0] thr_eff;
    logic [7:0] head, cpu_rdata;
    logic       unused_bits;

    assign cpu_sel = !bus.address_enable_n && (bus.address[9:2] == BASE_ADDR[9:2]);
    assign dma_act = (state_q == ACK) && !bus.dma_acknowledge_n;
    assign rd_rise = !io_read_n_q && bus.io_read_n;
    assign rd_fall = io_read_n_q && !bus.io_read_n;
    assign wr_rise = !io_write_n_q && bus.io_write_n;
    assign wr_fall = io_write_n_q && !bus.io_write_n;

    // Producer handshake: a byte moves on every clock where rx_valid and rx_ready are both
    // high; rx_data must hold steady while rx_valid waits on a low rx_ready.
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign rx_ready = !full;
    assign push     = rx_valid && !full;
    assign pop      = rd_rise && !empty && (dma_act || (cpu_sel && bus.address[1:0] == 2'd0));

    assign flush   = wr_pend_q && (wr_reg_q == 2'd2) && wr_data_q[2];
    assign clr     = wr_pend_q && (wr_reg_q == 2'd2) && wr_data_q[3];
    assign tc_now  = rd_rise && dma_act && (tc_latch_q || !bus.terminal_count_n);
    assign thr_eff = (thresh_q == '0) ? 5'd1 : thresh_q;
    assign thr_met = 32'(count_q) >= 32'(thr_eff);
    assign head    = empty ? 8'hFF : mem_q[rd_ptr_q];

    always_comb begin
        cpu_rdata = 8'h00;
        case (bus.address[1:0])
            2'd0:    cpu_rdata = head;
            2'd1:    cpu_rdata = {irq_pending_q, tc_seen_q, full, 5'(count_q)};
            2'd2:    cpu_rdata = {6'b0, irq_en_q, dma_en_q};
            default: cpu_rdata = {3'b0, thresh_q};
        endcase
    end

    // During an acknowledged DMA cycle the card owns the bus regardless of AEN and address.
    assign bus.data_bus_out_en   = !bus.io_read_n && (dma_act || cpu_sel);
    assign bus.data_bus_out      = !bus.data_bus_out_en ? 8'h00 : (dma_act ? head : cpu_rdata);
    assign bus.io_channel_ready  = (ws_cnt_q == '0);
    assign bus.dma_request       = dreq_q;
    assign bus.interrupt_request = irq_q;
    assign bus.dma_state_dbg     = state_q;

    assign unused_bits = ^{bus.address[19:10], wr_data_q[7:5]};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[wr_ptr_q] <= rx_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            dma_en_q      <= 1'b0;
            irq_en_q      <= 1'b0;
            tc_seen_q     <= 1'b0;
            irq_pending_q <= 1'b0;
            tc_latch_q    <= 1'b0;
            thresh_q      <= '0;
            io_read_n_q   <= 1'b1;
            io_write_n_q  <= 1'b1;
            wr_pend_q     <= 1'b0;
            wr_reg_q      <= '0;
            wr_data_q     <= '0;
            ws_cnt_q      <= '0;
            dreq_q        <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            io_read_n_q  <= bus.io_read_n;
            io_write_n_q <= bus.io_write_n;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;

            if ((rd_fall || wr_fall) && (cpu_sel || !bus.dma_acknowledge_n))
                ws_cnt_q <= 8'(WAIT_STATES);
            else if (ws_cnt_q != '0)
                ws_cnt_q <= ws_cnt_q - 8'd1;

            // Write data is latched on the strobe's trailing edge and applied one clock later.
            wr_pend_q <= wr_rise && cpu_sel;
            if (wr_rise && cpu_sel) begin
                wr_reg_q  <= bus.address[1:0];
                wr_data_q <= bus.data_bus_in;
            end
            if (wr_pend_q && wr_reg_q == 2'd2) begin
                dma_en_q <= wr_data_q[0];
                irq_en_q <= wr_data_q[1];
            end
            if (wr_pend_q && wr_reg_q == 2'd3) thresh_q <= wr_data_q[4:0];
            if (clr) begin
                tc_seen_q     <= 1'b0;
                irq_pending_q <= 1'b0;
            end
            if (tc_now) begin
                tc_seen_q     <= 1'b1;
                irq_pending_q <= 1'b1;
                dma_en_q      <= 1'b0;
            end
            irq_q <= irq_pending_q && irq_en_q;

            case (state_q)
                IDLE: begin
                    if (dma_en_q && thr_met) begin
                        state_q <= REQ;
                        dreq_q  <= 1'b1;
                    end
                end
                REQ: begin
                    if (!dma_en_q) begin
                        state_q <= IDLE;
                        dreq_q  <= 1'b0;
                    end else if (!bus.dma_acknowledge_n) begin
                        state_q <= ACK;
                        dreq_q  <= 1'b0;
                    end
                end
                ACK: begin
                    if (!bus.dma_acknowledge_n && !bus.terminal_count_n) tc_latch_q <= 1'b1;
                    if (bus.dma_acknowledge_n) begin
                        state_q    <= IDLE;
                        tc_latch_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    dreq_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_isa_dma_fifo_target.sv
// Self-checking bench for isa_dma_fifo_target: CPU port cycles, DMA transfers, TC/IRQ,
// FIFO full/flush, unselected cycles and reset during an acknowledged transfer.
module tb_isa_dma_fifo_target;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  logic [7:0] rd;
  int nr;
  logic oe;
  logic dq;

  isa_dma_fifo_target_if bus();

  isa_dma_fifo_target #(
    .BASE_ADDR(10'h300),
    .FIFO_DEPTH(16),
    .WAIT_STATES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sb_next();
    if (exp_q.size() == 0) return 8'hFF;
    return exp_q.pop_front();
  endfunction

  // drivers
  task automatic push_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1 rx_valid = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic io_read(input logic [9:0] addr, output logic [7:0] rdata, output int nrdy,
                         output logic en);
    @(negedge clock);
    bus.address = {10'h000, addr};
    bus.address_enable_n = 1'b0;
    @(negedge clock);
    bus.io_read_n = 1'b0;
    nrdy = 0;
    repeat (4) begin
      @(negedge clock);
      if (!bus.io_channel_ready) nrdy++;
    end
    rdata = bus.data_bus_out;
    en = bus.data_bus_out_en;
    bus.io_read_n = 1'b1;
    @(negedge clock);
    bus.address_enable_n = 1'b1;
  endtask

  task automatic io_write(input logic [9:0] addr, input logic [7:0] d);
    @(negedge clock);
    bus.address = {10'h000, addr};
    bus.address_enable_n = 1'b0;
    bus.data_bus_in = d;
    @(negedge clock);
    bus.io_write_n = 1'b0;
    repeat (3) @(negedge clock);
    bus.io_write_n = 1'b1;
    @(negedge clock);
    bus.address_enable_n = 1'b1;
  endtask

  task automatic dma_read(input logic tc, output logic [7:0] rdata, output int nrdy,
                          output logic en, output logic dreq);
    @(negedge clock);
    bus.address_enable_n = 1'b1;
    bus.dma_acknowledge_n = 1'b0;
    bus.terminal_count_n = !tc;
    @(negedge clock);
    bus.io_read_n = 1'b0;
    nrdy = 0;
    repeat (4) begin
      @(negedge clock);
      if (!bus.io_channel_ready) nrdy++;
    end
    rdata = bus.data_bus_out;
    en = bus.data_bus_out_en;
    dreq = bus.dma_request;
    bus.io_read_n = 1'b1;
    @(negedge clock);
    bus.dma_acknowledge_n = 1'b1;
    bus.terminal_count_n = 1'b1;
  endtask

  task automatic wait_dreq(input string tag);
    for (int i = 0; i < 20 && !bus.dma_request; i++) @(negedge clock);
    check_eq(tag, bus.dma_request, 1);
  endtask

  initial begin
    bus.address = '0;
    bus.address_enable_n = 1'b1;
    bus.io_read_n = 1'b1;
    bus.io_write_n = 1'b1;
    bus.data_bus_in = '0;
    bus.dma_acknowledge_n = 1'b1;
    bus.terminal_count_n = 1'b1;
    rx_data = '0;
    rx_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // reset state
    check_eq("rst_oe", bus.data_bus_out_en, 0);
    check_eq("rst_dout", bus.data_bus_out, 0);
    check_eq("rst_ready", bus.io_channel_ready, 1);
    check_eq("rst_dreq", bus.dma_request, 0);
    check_eq("rst_irq", bus.interrupt_request, 0);
    check_eq("rst_rx_ready", rx_ready, 1);
    check_eq("rst_state", bus.dma_state_dbg, 0);
    io_read(10'h301, rd, nr, oe);
    check_eq("rst_status", rd, 8'h00);

    // CPU port reads with wait states
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    io_read(10'h300, rd, nr, oe);
    check_eq("t2_data0", rd, sb_next());
    check_eq("t2_oe", oe, 1);
    check_eq("t2_wait0", nr, 2);
    io_read(10'h300, rd, nr, oe);
    check_eq("t2_data1", rd, sb_next());
    check_eq("t2_wait1", nr, 2);
    io_read(10'h301, rd, nr, oe);
    check_eq("t2_status", rd, 8'h01);
    check_eq("t2_wait2", nr, 2);
    io_read(10'h300, rd, nr, oe);
    check_eq("t2_data2", rd, sb_next());
    io_read(10'h300, rd, nr, oe);
    check_eq("t2_empty", rd, sb_next());
    check_eq("t2_empty_oe", oe, 1);

    // unselected (AEN high, no DACK) cycle
    push_byte(8'h77);
    @(negedge clock);
    bus.address = 20'h00300;
    bus.address_enable_n = 1'b1;
    bus.io_read_n = 1'b0;
    nr = 0;
    oe = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (!bus.io_channel_ready) nr++;
      if (bus.data_bus_out_en) oe = 1'b1;
    end
    bus.io_read_n = 1'b1;
    @(negedge clock);
    check_eq("t6_oe", oe, 0);
    check_eq("t6_wait", nr, 0);
    io_read(10'h301, rd, nr, oe);
    check_eq("t6_status", rd, 8'h01);
    io_read(10'h300, rd, nr, oe);
    check_eq("t6_data", rd, sb_next());

    // DMA transfers against a threshold of 4
    io_write(10'h303, 8'h04);
    io_write(10'h302, 8'h03);
    io_read(10'h302, rd, nr, oe);
    check_eq("t3_ctrl", rd, 8'h03);
    io_read(10'h303, rd, nr, oe);
    check_eq("t3_thresh", rd, 8'h04);
    push_byte(8'hA0);
    push_byte(8'hA1);
    push_byte(8'hA2);
    repeat (3) @(negedge clock);
    check_eq("t3_dreq_below", bus.dma_request, 0);
    push_byte(8'hA3);
    wait_dreq("t3_dreq0");
    dma_read(1'b0, rd, nr, oe, dq);
    check_eq("t3_dma0", rd, sb_next());
    check_eq("t3_dma0_oe", oe, 1);
    check_eq("t3_dma0_wait", nr, 2);
    check_eq("t3_dreq_in_ack", dq, 0);
    repeat (3) @(negedge clock);
    check_eq("t3_dreq_cnt3", bus.dma_request, 0);
    io_read(10'h301, rd, nr, oe);
    check_eq("t3_status", rd, 8'h03);
    push_byte(8'hA4);
    wait_dreq("t3_dreq1");
    dma_read(1'b0, rd, nr, oe, dq);
    check_eq("t3_dma1", rd, sb_next());

    // terminal count on the last byte
    io_write(10'h303, 8'h01);
    wait_dreq("t4_dreq0");
    dma_read(1'b0, rd, nr, oe, dq);
    check_eq("t4_dma0", rd, sb_next());
    wait_dreq("t4_dreq1");
    dma_read(1'b0, rd, nr, oe, dq);
    check_eq("t4_dma1", rd, sb_next());
    wait_dreq("t4_dreq2");
    dma_read(1'b1, rd, nr, oe, dq);
    check_eq("t4_dma_tc", rd, sb_next());
    repeat (2) @(negedge clock);
    check_eq("t4_irq_set", bus.interrupt_request, 1);
    io_read(10'h301, rd, nr, oe);
    check_eq("t4_status_tc", rd, 8'hC0);
    io_read(10'h302, rd, nr, oe);
    check_eq("t4_ctrl_dma_off", rd, 8'h02);
    check_eq("t4_dreq_off", bus.dma_request, 0);
    io_write(10'h302, 8'h0A);
    repeat (2) @(negedge clock);
    check_eq("t4_irq_clr", bus.interrupt_request, 0);
    io_read(10'h301, rd, nr, oe);
    check_eq("t4_status_clr", rd, 8'h00);

    // full FIFO, refill while held, flush
    for (int i = 0; i < 16; i++) push_byte(8'($urandom_range(0, 255)));
    @(negedge clock);
    check_eq("t5_rx_ready_full", rx_ready, 0);
    io_read(10'h301, rd, nr, oe);
    check_eq("t5_status_full", rd, 8'h30);
    @(negedge clock);
    rx_data = 8'h5C;
    rx_valid = 1'b1;
    io_read(10'h300, rd, nr, oe);
    check_eq("t5_pop_full", rd, sb_next());
    exp_q.push_back(8'h5C);
    @(negedge clock);
    rx_valid = 1'b0;
    check_eq("t5_rx_ready_refull", rx_ready, 0);
    io_read(10'h301, rd, nr, oe);
    check_eq("t5_status_refull", rd, 8'h30);
    io_read(10'h300, rd, nr, oe);
    check_eq("t5_data_after_refill", rd, sb_next());
    io_write(10'h302, 8'h04);
    exp_q.delete();
    io_read(10'h301, rd, nr, oe);
    check_eq("t5_status_flush", rd, 8'h00);
    io_read(10'h300, rd, nr, oe);
    check_eq("t5_data_flush", rd, sb_next());
    check_eq("t5_rx_ready_flush", rx_ready, 1);

    // reset during an acknowledged read
    io_write(10'h302, 8'h03);
    push_byte(8'h99);
    wait_dreq("t1_dreq");
    @(negedge clock);
    bus.address_enable_n = 1'b1;
    bus.dma_acknowledge_n = 1'b0;
    @(negedge clock);
    bus.io_read_n = 1'b0;
    @(negedge clock);
    check_eq("t1_oe_before", bus.data_bus_out_en, 1);
    reset = 1'b1;
    @(negedge clock);
    check_eq("t1_oe", bus.data_bus_out_en, 0);
    check_eq("t1_dout", bus.data_bus_out, 0);
    check_eq("t1_ready", bus.io_channel_ready, 1);
    check_eq("t1_dreq", bus.dma_request, 0);
    check_eq("t1_irq", bus.interrupt_request, 0);
    check_eq("t1_rx_ready", rx_ready, 1);
    check_eq("t1_state", bus.dma_state_dbg, 0);
    bus.io_read_n = 1'b1;
    bus.dma_acknowledge_n = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    io_read(10'h301, rd, nr, oe);
    check_eq("t1_status", rd, 8'h00);
    io_read(10'h302, rd, nr, oe);
    check_eq("t1_ctrl", rd, 8'h00);
    io_read(10'h300, rd, nr, oe);
    check_eq("t1_data", rd, sb_next());
    check_eq("t1_dreq_after", bus.dma_request, 0);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
